// File: rtl/shield_pkg.sv
// Shared definitions for the shield collision arbiter.
//   N_AMSL_DEFAULT : default number of alien missiles
//   CNT_W_DEFAULT  : default width of the saturating shield-hit counter
//   shield_ctl_st_t: arbiter state (IDLE while no game runs, ACTIVE during play)
package shield_pkg;

    localparam int N_AMSL_DEFAULT = 4;
    localparam int CNT_W_DEFAULT  = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } shield_ctl_st_t;

endpackage : shield_pkg

// File: rtl/msl_frame_flag.sv
// Per-missile frame flag: remembers whether one missile has already carved the
// shield during the current frame, and reports that at the next frame boundary.
// Ports:
//   clk, resetN : pixel clock, asynchronous active-low reset
//   run         : arbiter is ACTIVE and stays ACTIVE this edge; low clears all
//   sof         : start-of-frame pulse (report old flag, then clear)
//   set         : missile overlaps the shield on this pixel
//   used        : flag, high from the pixel after the first overlap in a frame
//   hit_pulse   : 1-cycle report of the previous frame's flag
module msl_frame_flag (
    input  logic clk,
    input  logic resetN,
    input  logic run,
    input  logic sof,
    input  logic set,
    output logic used,
    output logic hit_pulse
);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            used      <= 1'b0;
            hit_pulse <= 1'b0;
        end else if (!run) begin
            // Leaving (or sitting in) IDLE: drop the flag without reporting it.
            used      <= 1'b0;
            hit_pulse <= 1'b0;
        end else begin
            hit_pulse <= sof & used;
            // An overlap on the frame-boundary pixel belongs to the new frame,
            // so set wins over the boundary clear.
            if (set) begin
                used <= 1'b1;
            end else if (sof) begin
                used <= 1'b0;
            end
        end
    end

endmodule : msl_frame_flag

// File: rtl/shield_collision_ctrl.sv
// Pixel-rate collision arbiter in front of the shield bitmap.
// Ports:
//   clk, resetN         : pixel clock, asynchronous active-low reset
//   startOfFrame        : 1-cycle frame-boundary pulse
//   playGame            : game running; low returns to IDLE
//   shieldDR            : shield drawing request for the current pixel
//   playerMslDR         : player missile drawing request
//   alienMslDR          : alien missile drawing requests (bit i = missile i)
//   aliensDR            : alien block drawing request
//   shieldCarve         : combinational carve request to the bitmap
//   shieldAlienKill     : combinational alien/shield kill to the bitmap
//   playerMslShieldHit  : 1-cycle pulse, player missile hit the shield last frame
//   alienMslShieldHit   : 1-cycle pulses per alien missile, hit last frame
//   shieldHitCount      : saturating count of carve cycles since game start
module shield_collision_ctrl
    import shield_pkg::*;
#(
    parameter int N_AMSL = N_AMSL_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              startOfFrame,
    input  logic              playGame,
    input  logic              shieldDR,
    input  logic              playerMslDR,
    input  logic [N_AMSL-1:0] alienMslDR,
    input  logic              aliensDR,
    output logic              shieldCarve,
    output logic              shieldAlienKill,
    output logic              playerMslShieldHit,
    output logic [N_AMSL-1:0] alienMslShieldHit,
    output logic [CNT_W-1:0]  shieldHitCount
);

    shield_ctl_st_t state;

    logic            active;
    logic            run;
    // Index 0 is the player missile, 1..N_AMSL the alien missiles.
    logic [N_AMSL:0] msl_dr;
    logic [N_AMSL:0] msl_used;
    logic [N_AMSL:0] msl_pulse;

    assign active = (state == ACTIVE);
    assign run    = active & playGame;
    assign msl_dr = {alienMslDR, playerMslDR};

    // Only missiles that have not yet carved in this frame may carve; several
    // fresh missiles on the same pixel still give a single carve cycle.
    assign shieldCarve     = active & shieldDR & (|(msl_dr & ~msl_used));
    assign shieldAlienKill = active & shieldDR & aliensDR;

    assign playerMslShieldHit = msl_pulse[0];
    assign alienMslShieldHit  = msl_pulse[N_AMSL:1];

    generate
        for (genvar gi = 0; gi <= N_AMSL; gi++) begin : g_flag
            msl_frame_flag u_flag (
                .clk       (clk),
                .resetN    (resetN),
                .run       (run),
                .sof       (startOfFrame),
                .set       (shieldDR & msl_dr[gi]),
                .used      (msl_used[gi]),
                .hit_pulse (msl_pulse[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state          <= IDLE;
            shieldHitCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Counter holds in IDLE and restarts with each new game.
                    if (startOfFrame && playGame) begin
                        state          <= ACTIVE;
                        shieldHitCount <= '0;
                    end
                end
                ACTIVE: begin
                    if (shieldCarve && (shieldHitCount != {CNT_W{1'b1}})) begin
                        shieldHitCount <= shieldHitCount + 1'b1;
                    end
                    if (!playGame) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule : shield_collision_ctrl

// File: tb/tb_shield_collision_ctrl.sv
module tb_shield_collision_ctrl;

    logic        clk = 1'b0;
    logic        resetN;
    logic        sof;
    logic        pg;
    logic        sdr;
    logic        pdr;
    logic [3:0]  adr;
    logic        aldr;
    logic        carve;
    logic        kill;
    logic        pm_hit;
    logic [3:0]  am_hit;
    logic [15:0] cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt;

    always #5 clk = ~clk;

    shield_collision_ctrl #(.N_AMSL(4), .CNT_W(16)) dut (
        .clk                (clk),
        .resetN             (resetN),
        .startOfFrame       (sof),
        .playGame           (pg),
        .shieldDR           (sdr),
        .playerMslDR        (pdr),
        .alienMslDR         (adr),
        .aliensDR           (aldr),
        .shieldCarve        (carve),
        .shieldAlienKill    (kill),
        .playerMslShieldHit (pm_hit),
        .alienMslShieldHit  (am_hit),
        .shieldHitCount     (cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %0d %s observed=%0h expected=%0h", checks, tag, obs, exp);
    endtask

    // Advance one clock: returns at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic s, input logic sd, input logic pm,
                         input logic [3:0] am, input logic al);
        sof  = s;
        sdr  = sd;
        pdr  = pm;
        adr  = am;
        aldr = al;
    endtask

    // One-cycle frame boundary with no drawing requests.
    task automatic frame();
        drive(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    endtask

    initial begin
        resetN = 1'b0;
        pg     = 1'b0;
        // Requests present during reset must not leak through.
        drive(1'b0, 1'b1, 1'b1, 4'b1111, 1'b1);
        tick();
        tick();
        chk("rst_carve", carve, 0);
        chk("rst_kill", kill, 0);
        chk("rst_pm_hit", pm_hit, 0);
        chk("rst_am_hit", am_hit, 0);
        chk("rst_cnt", cnt, 0);
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        resetN = 1'b1;
        tick();

        // 1: start game, player missile on shield for 3 pixels
        pg = 1'b1;
        frame();
        drive(1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
        #1 chk("t1_carve_1st", carve, 1);
        tick();
        chk("t1_carve_2nd", carve, 0);
        chk("t1_cnt", cnt, 1);
        tick();
        chk("t1_carve_3rd", carve, 0);
        tick();
        chk("t1_cnt_after", cnt, 1);
        drive(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        #1 chk("t1_pm_before_sof", pm_hit, 0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        chk("t1_pm_pulse", pm_hit, 1);
        chk("t1_am_pulse", am_hit, 0);
        tick();
        chk("t1_pm_pulse_end", pm_hit, 0);

        // 2: two alien missiles hit on the same pixel
        drive(1'b0, 1'b1, 1'b0, 4'b0101, 1'b0);
        #1 chk("t2_carve", carve, 1);
        tick();
        chk("t2_carve_next", carve, 0);
        chk("t2_cnt", cnt, 2);
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        frame();
        chk("t2_am_pulse", am_hit, 4'b0101);
        chk("t2_pm_pulse", pm_hit, 0);
        tick();
        chk("t2_am_pulse_end", am_hit, 0);
        frame();
        chk("t2_am_next_frame", am_hit, 4'b0000);

        // 3: alien block over shield for 5 pixels
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
            #1 chk("t3_kill", kill, 1);
            chk("t3_carve", carve, 0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        #1 chk("t3_kill_off", kill, 0);
        chk("t3_cnt", cnt, 2);

        // 4: overlap coincident with the frame boundary
        drive(1'b0, 1'b1, 1'b0, 4'b0100, 1'b0);
        tick();
        chk("t4_cnt_old", cnt, 3);
        drive(1'b1, 1'b1, 1'b1, 4'b0000, 1'b0);
        #1 chk("t4_carve_sof", carve, 1);
        tick();
        chk("t4_am_report", am_hit, 4'b0100);
        chk("t4_pm_report", pm_hit, 0);
        chk("t4_cnt_new", cnt, 4);
        drive(1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
        #1 chk("t4_carve_blocked", carve, 0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        frame();
        chk("t4_pm_next_frame", pm_hit, 1);
        chk("t4_am_next_frame", am_hit, 0);

        // 6a: playGame drops mid-frame after a hit
        drive(1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
        tick();
        chk("t6_cnt_hit", cnt, 5);
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        pg = 1'b0;
        tick();
        drive(1'b0, 1'b1, 1'b1, 4'b1111, 1'b1);
        #1 chk("t6_idle_carve", carve, 0);
        chk("t6_idle_kill", kill, 0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        tick();
        chk("t6_idle_pm_pulse", pm_hit, 0);
        chk("t6_idle_cnt_held", cnt, 5);
        pg = 1'b1;
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        chk("t6_reenable_cnt", cnt, 0);

        // 6b: asynchronous reset mid-frame
        drive(1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
        tick();
        chk("t6_cnt_before_rst", cnt, 1);
        drive(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
        #1 chk("t6_kill_before_rst", kill, 1);
        #1 resetN = 1'b0;
        #1 chk("t6_rst_kill", kill, 0);
        chk("t6_rst_cnt", cnt, 0);
        chk("t6_rst_pm", pm_hit, 0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        resetN = 1'b1;
        tick();
        frame();

        // 5: drive the counter to 16'hFFFE with real carves, then saturate
        exp_cnt = 0;
        while (exp_cnt < 32'hFFFE) begin
            for (int j = 0; j < 5 && exp_cnt < 32'hFFFE; j++) begin
                if (j == 0) drive(1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
                else        drive(1'b0, 1'b1, 1'b0, 4'(1 << (j - 1)), 1'b0);
                tick();
                exp_cnt++;
            end
            frame();
        end
        chk("t5_cnt_fffe", cnt, 16'hFFFE);
        drive(1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
        #1 chk("t5_carve_a", carve, 1);
        tick();
        chk("t5_cnt_ffff", cnt, 16'hFFFF);
        frame();
        drive(1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
        #1 chk("t5_carve_b", carve, 1);
        tick();
        chk("t5_cnt_sat", cnt, 16'hFFFF);
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_shield_collision_ctrl
